// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-subset control FSM with registered Moore outputs.
// Define ILLEGAL_TRAP_EN to trap unsupported opcodes; otherwise they execute as NOP.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCSource,
    output logic [2:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        RTWB   = 4'd7,
        BRANCH = 4'd8,
        IMMEX  = 4'd9,
        IMMWB  = 4'd10,
        TRAP   = 4'd11
    } state_t;
    typedef struct packed {
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_source;
        logic [2:0] alu_op;
        logic       fetch;
    } ctrl_t;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
`ifdef ILLEGAL_TRAP_EN
    localparam state_t BAD_NEXT = TRAP;
`else
    localparam state_t BAD_NEXT = FETCH;
`endif
    state_t     st, nxt, dec_next;
    logic [5:0] op_q, nxt_op;
    ctrl_t      ctrl_q;
    function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.fetch     = 1'b1;
            end
            DECODE: c.alu_src_b = 2'b11;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            RTEX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'b010;
            end
            RTWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 3'b001;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 1'b1;
            end
            IMMEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = op == OP_ANDI ? 3'b011 : op == OP_ORI ? 3'b100 : 3'b000;
            end
            IMMWB: c.reg_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction
    always_comb begin
        dec_next = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                   opcode == OP_RT  ? RTEX :
                   opcode == OP_BEQ ? BRANCH :
                   (opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI) ? IMMEX : BAD_NEXT;
        nxt    = FETCH;
        nxt_op = op_q;
        case (st)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                nxt    = dec_next;
                nxt_op = opcode;
            end
            MEMADR: nxt = op_q == OP_LW ? MEMRD : MEMWR;
            MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
            RTEX:   nxt = RTWB;
            IMMEX:  nxt = IMMWB;
            TRAP:   nxt = TRAP;
            default: nxt = FETCH;
        endcase
    end
    // Outputs are registered from the next state so they line up with st on every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= FETCH;
            op_q   <= '0;
            ctrl_q <= decode(FETCH, 6'd0);
        end else begin
            st     <= nxt;
            op_q   <= nxt_op;
            ctrl_q <= decode(nxt, nxt_op);
        end
    end
`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else if (st == DECODE && dec_next == TRAP)
            illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif
    // PC/IR update is the one strobe that follows the memory handshake directly.
    assign PCWrite     = ctrl_q.fetch & mem_ready;
    assign IRWrite     = ctrl_q.fetch & mem_ready;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign PCSource    = ctrl_q.pc_source;
    assign ALUOp       = ctrl_q.alu_op;
    assign state       = st;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multicycle control FSM.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, PCSource, illegal;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [3:0] state;
    int total = 0;
    int bad = 0;
    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .state(state), .illegal(illegal)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Walks a mem_ready=1 instruction from FETCH, checking state and write-back strobes.
    task automatic run_seq(input string tag, input logic [5:0] op, input int n,
                           input logic [3:0] seq [6], input logic [3:0] wb_state);
        opcode = op;
        for (int i = 0; i < n; i++) begin
            check({tag, "_state"}, state, seq[i]);
            check({tag, "_regwrite"}, RegWrite, seq[i] == wb_state);
            if (i < n - 1) tick();
        end
    endtask
    initial begin
        logic [3:0] seq [6];
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'b100011;
        tick();
        tick();
        check("rst_state", state, 0);
        check("rst_memread", MemRead, 1);
        check("rst_alusrcb", ALUSrcB, 2'b01);
        check("rst_illegal", illegal, 0);
        check("rst_regwrite", RegWrite, 0);
        rst_n = 1'b1;
        seq = '{0, 1, 2, 3, 4, 0};
        run_seq("lw", 6'b100011, 6, seq, 4);
        seq = '{0, 1, 6, 7, 0, 0};
        run_seq("rtype", 6'b000000, 5, seq, 7);
        // FETCH wait: PC/IR strobes must not pulse until mem_ready
        mem_ready = 1'b0;
        tick();
        check("fwait_state", state, 0);
        check("fwait_irwrite", IRWrite, 0);
        check("fwait_pcwrite", PCWrite, 0);
        check("fwait_memread", MemRead, 1);
        mem_ready = 1'b1;
        #1;
        check("fready_irwrite", IRWrite, 1);
        check("fready_pcwrite", PCWrite, 1);
        opcode = 6'b000100;
        tick();
        check("beq_dec_state", state, 1);
        check("beq_dec_alusrcb", ALUSrcB, 2'b11);
        check("beq_dec_pcwrite", PCWrite, 0);
        tick();
        check("beq_state", state, 8);
        check("beq_aluop", ALUOp, 3'b001);
        check("beq_pcwc", PCWriteCond, 1);
        check("beq_pcsrc", PCSource, 1);
        check("beq_pcwrite", PCWrite, 0);
        check("beq_alusrca", ALUSrcA, 1);
        tick();
        check("beq_done", state, 0);
        opcode = 6'b001101;
        tick();
        tick();
        check("ori_state", state, 9);
        check("ori_aluop", ALUOp, 3'b100);
        check("ori_alusrcb", ALUSrcB, 2'b10);
        opcode = 6'b000000;
        tick();
        check("ori_wb_state", state, 10);
        check("ori_wb_regwrite", RegWrite, 1);
        check("ori_wb_regdst", RegDst, 0);
        check("ori_wb_memtoreg", MemtoReg, 0);
        tick();
        check("ori_done", state, 0);
        opcode = 6'b001100;
        tick();
        tick();
        check("andi_aluop", ALUOp, 3'b011);
        tick();
        tick();
        // sw with mem_ready low in MEMADR (ignored) and 3 wait cycles in MEMWR
        opcode = 6'b101011;
        tick();
        tick();
        check("sw_adr_state", state, 2);
        mem_ready = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("sw_wr_state", state, 5);
            check("sw_memwrite", MemWrite, 1);
            check("sw_iord", IorD, 1);
            check("sw_regwrite", RegWrite, 0);
            check("sw_pcwrite", PCWrite, 0);
            if (k == 3) mem_ready = 1'b1;
            tick();
        end
        check("sw_done", state, 0);
        check("sw_done_memwrite", MemWrite, 0);
        // async reset during a stalled MEMRD
        opcode = 6'b100011;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        check("mrd_state", state, 3);
        check("mrd_iord", IorD, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_memread", MemRead, 1);
        check("arst_iord", IorD, 0);
        check("arst_illegal", illegal, 0);
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b111111;
        tick();
        check("ill_dec_state", state, 1);
        tick();
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 10; k++) begin
            check("trap_state", state, 11);
            check("trap_illegal", illegal, 1);
            check("trap_memread", MemRead, 0);
            check("trap_pcwrite", PCWrite, 0);
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("trap_rst_illegal", illegal, 0);
        check("trap_rst_state", state, 0);
        rst_n = 1'b1;
`else
        check("nop_state", state, 0);
        check("nop_illegal", illegal, 0);
        tick();
        check("nop_next_state", state, 1);
        check("nop_next_illegal", illegal, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
